// File: rtl/limitador_activacion_pipe.sv
// Two-stage activation limiter. Each beat carries CHANNELS signed fixed-point
// samples that are passed through, rectified (ReLU) or clamped to a window.
// S1 captures the beat together with its mode and bounds, and S2 holds the
// limited result plus per-channel saturation flags. A valid/ready handshake
// provides backpressure.
// FRAC only documents the fixed-point scaling. The limiting needs plain
// signed compares, so the binary point position never enters the logic.
module limitador_activacion_pipe #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 24,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [1:0]                mode,
  input  logic [WIDTH-1:0]          lo_bound,
  input  logic [WIDTH-1:0]          hi_bound,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       sat_flags,
  output logic [15:0]               sat_count,
  input  logic                      clr_count
);

  typedef enum logic [1:0] {
    MODE_PASS      = 2'b00,
    MODE_RELU      = 2'b01,
    MODE_CLAMP     = 2'b10,
    MODE_CLAMP_POS = 2'b11
  } mode_t;

  logic                       s1_valid;
  logic [CHANNELS*WIDTH-1:0]  s1_data;
  mode_t                      s1_mode;
  logic signed [WIDTH-1:0]    s1_lo;
  logic signed [WIDTH-1:0]    s1_hi;

  logic                       s2_valid;
  logic [CHANNELS*WIDTH-1:0]  s2_data;
  logic [CHANNELS-1:0]        s2_flags;

  logic                       s2_adv;
  logic                       s1_adv;
  logic [CHANNELS*WIDTH-1:0]  lim_data;
  logic [CHANNELS-1:0]        lim_flags;

  // The upper bound is tested first, so an inverted window (lo > hi) still
  // resolves deterministically: above hi gives hi, anything else gives lo.
  function automatic logic [WIDTH-1:0] limit_sample(
    input logic signed [WIDTH-1:0] x,
    input mode_t                   m,
    input logic signed [WIDTH-1:0] lo,
    input logic signed [WIDTH-1:0] hi
  );
    logic signed [WIDTH-1:0] r;
    r = x;
    case (m)
      MODE_PASS:      r = x;
      MODE_RELU:      r = x[WIDTH-1] ? '0 : x;
      MODE_CLAMP:     r = (x > hi) ? hi : ((x < lo) ? lo : x);
      MODE_CLAMP_POS: r = x[WIDTH-1] ? '0 : ((x > hi) ? hi : x);
      default:        r = x;
    endcase
    return r;
  endfunction

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv && !rst;
  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign sat_flags = s2_flags;

  // Limit every channel of the beat held in S1 and flag the channels that changed
  always_comb begin
    lim_data  = '0;
    lim_flags = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      lim_data[c*WIDTH +: WIDTH] = limit_sample(s1_data[c*WIDTH +: WIDTH], s1_mode, s1_lo, s1_hi);
      lim_flags[c] = (lim_data[c*WIDTH +: WIDTH] != s1_data[c*WIDTH +: WIDTH]);
    end
  end

  // S1 captures the incoming beat along with the mode and bounds that apply to it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= MODE_PASS;
      s1_lo    <= '0;
      s1_hi    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_mode <= mode_t'(mode);
        s1_lo   <= lo_bound;
        s1_hi   <= hi_bound;
      end
    end
  end

  // S2 holds the limited result and stays frozen while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_flags <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data  <= lim_data;
        s2_flags <= lim_flags;
      end
    end
  end

  // Count delivered beats that saturated any channel; clear wins, no wraparound
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (clr_count) begin
      sat_count <= '0;
    end else if (s2_valid && out_ready && (|s2_flags) && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

endmodule
